// File: rtl/gcd_unit.sv
// Euclid-by-subtraction GCD engine. It takes one operand pair per request and performs one
// subtraction per cycle, then returns the result and the step count over a valid/ready port.
module gcd_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] gcd_o,
  output logic [WIDTH-1:0] steps_o
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [WIDTH-1:0] steps_q, steps_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      steps_q <= steps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    steps_d = steps_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          steps_d = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Zero operands terminate first, so gcd(0,0) yields 0 without subtracting.
        if (a_q == '0) begin
          gcd_d   = b_q;
          state_d = StDone;
        end else if (b_q == '0) begin
          gcd_d   = a_q;
          state_d = StDone;
        end else if (a_q == b_q) begin
          gcd_d   = a_q;
          state_d = StDone;
        end else if (a_q > b_q) begin
          a_d     = a_q - b_q;
          steps_d = steps_q + One;
        end else begin
          b_d     = b_q - a_q;
          steps_d = steps_q + One;
        end
      end
      StDone: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StDone);
  assign gcd_o        = gcd_q;
  assign steps_o      = steps_q;

endmodule
